axi_lite_csr_bridge: RTL and testbench

AXI4-Lite slave that terminates the host control port and drives the accelerator's single-cycle CSR bus (csr_wen/csr_ren/csr_addr/csr_wdata/csr_rdata). It sits directly upstream of the CSR register file. It serialises reads and writes and decodes illegal accesses into SLVERR. It also exposes an error counter for debug.

---
 rtl/axi_csr_pkg.sv | 27 ++
 rtl/axi_lite_csr_bridge.sv | 234 +++++++++++++++++++++++
 tb/tb_axi_lite_csr_bridge.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_csr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_csr_pkg
//  Description : Shared types and constants for the AXI4-Lite to CSR bridge.
//                Provides AXI response codes, the bridge FSM state encoding
//                and the read/write grant encoding used by the arbiter.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package axi_csr_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BRESP = 2'd1,
    RRESP = 2'd2
  } bridge_state_e;

  typedef enum logic {
    GRANT_READ  = 1'b0,
    GRANT_WRITE = 1'b1
  } grant_e;

endpackage
`default_nettype wire

// File: rtl/axi_lite_csr_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_csr_bridge
//  Description : AXI4-Lite slave terminating the host control port and
//                driving a single-cycle CSR bus. AW, W and AR each have a
//                one-entry hold register; an IDLE/BRESP/RRESP FSM serialises
//                accesses with round-robin arbitration between a complete
//                write (AW+W held) and a held read. Misaligned addresses and
//                partial write strobes are answered with SLVERR and never
//                reach the CSR bus. err_count counts SLVERRs, saturating.
//  Ports       : clk, rst_n (sync, active-low)
//                s_axi_aw*/w*/b*  AXI4-Lite write channels
//                s_axi_ar*/r*     AXI4-Lite read channels
//                csr_wen/csr_ren  one-cycle CSR strobes
//                csr_addr/csr_wdata/csr_rdata  CSR address and data
//                err_count        saturating SLVERR counter
//  Revision    : 1.0  initial release
// ============================================================================
module axi_lite_csr_bridge
  import axi_csr_pkg::*;
#(
  parameter int AXI_ADDR_W = 32,
  parameter int CSR_ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [AXI_ADDR_W-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [AXI_ADDR_W-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic                  csr_wen,
  output logic                  csr_ren,
  output logic [CSR_ADDR_W-1:0] csr_addr,
  output logic [31:0]           csr_wdata,
  input  logic [31:0]           csr_rdata,
  output logic [15:0]           err_count
);

  localparam logic [15:0] C_ERR_MAX = 16'hFFFF;

  bridge_state_e         r_state;
  bridge_state_e         w_next_state;
  grant_e                r_last_grant;

  logic                  r_aw_held;
  logic [CSR_ADDR_W-1:0] r_aw_addr;
  logic                  r_w_held;
  logic [31:0]           r_w_data;
  logic [3:0]            r_w_strb;
  logic                  r_ar_held;
  logic [CSR_ADDR_W-1:0] r_ar_addr;

  logic                  r_awready;
  logic                  r_wready;
  logic                  r_arready;
  logic [1:0]            r_bresp;
  logic [1:0]            r_rresp;
  logic [31:0]           r_rdata;
  logic [15:0]           r_err_count;

  logic                  w_aw_fire;
  logic                  w_w_fire;
  logic                  w_ar_fire;
  logic                  w_b_done;
  logic                  w_r_done;
  logic                  w_wr_legal;
  logic                  w_rd_legal;
  logic                  w_grant_wr;
  logic                  w_grant_rd;
  logic                  w_slverr;
  logic [CSR_ADDR_W-1:0] w_csr_addr;
  logic [31:0]           w_csr_wdata;

  // Upper address bits are decoded by the interconnect and deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr[AXI_ADDR_W-1:CSR_ADDR_W],
                              s_axi_araddr[AXI_ADDR_W-1:CSR_ADDR_W]};

  assign w_aw_fire  = s_axi_awvalid && r_awready;
  assign w_w_fire   = s_axi_wvalid  && r_wready;
  assign w_ar_fire  = s_axi_arvalid && r_arready;
  assign w_b_done   = (r_state == BRESP) && s_axi_bready;
  assign w_r_done   = (r_state == RRESP) && s_axi_rready;

  assign w_wr_legal = (r_aw_addr[1:0] == 2'b00) && (r_w_strb == 4'hF);
  assign w_rd_legal = (r_ar_addr[1:0] == 2'b00);
  assign w_slverr   = (w_grant_wr && !w_wr_legal) || (w_grant_rd && !w_rd_legal);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state, arbitration and CSR bus drive
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_grant_wr   = 1'b0;
    w_grant_rd   = 1'b0;
    w_csr_addr   = '0;
    w_csr_wdata  = '0;
    case (r_state)
      IDLE: begin
        // On contention the side that did not win last time goes first.
        if (r_aw_held && r_w_held && (!r_ar_held || r_last_grant == GRANT_READ)) begin
          w_grant_wr   = 1'b1;
          w_next_state = BRESP;
          w_csr_addr   = r_aw_addr;
          w_csr_wdata  = r_w_data;
        end else if (r_ar_held) begin
          w_grant_rd   = 1'b1;
          w_next_state = RRESP;
          w_csr_addr   = r_ar_addr;
        end
      end
      BRESP: begin
        if (s_axi_bready) begin
          w_next_state = IDLE;
        end
      end
      RRESP: begin
        if (s_axi_rready) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Hold registers, registered readies, responses and error counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_aw_held    <= 1'b0;
      r_aw_addr    <= '0;
      r_w_held     <= 1'b0;
      r_w_data     <= '0;
      r_w_strb     <= '0;
      r_ar_held    <= 1'b0;
      r_ar_addr    <= '0;
      r_awready    <= 1'b0;
      r_wready     <= 1'b0;
      r_arready    <= 1'b0;
      r_bresp      <= RESP_OKAY;
      r_rresp      <= RESP_OKAY;
      r_rdata      <= '0;
      r_err_count  <= '0;
      r_last_grant <= GRANT_READ;
    end else begin
      if (w_aw_fire) begin
        r_aw_held <= 1'b1;
        r_aw_addr <= s_axi_awaddr[CSR_ADDR_W-1:0];
      end else if (w_b_done) begin
        r_aw_held <= 1'b0;
      end

      if (w_w_fire) begin
        r_w_held <= 1'b1;
        r_w_data <= s_axi_wdata;
        r_w_strb <= s_axi_wstrb;
      end else if (w_b_done) begin
        r_w_held <= 1'b0;
      end

      if (w_ar_fire) begin
        r_ar_held <= 1'b1;
        r_ar_addr <= s_axi_araddr[CSR_ADDR_W-1:0];
      end else if (w_r_done) begin
        r_ar_held <= 1'b0;
      end

      // Each ready mirrors the next-cycle emptiness of its hold register.
      r_awready <= w_b_done || (!r_aw_held && !w_aw_fire);
      r_wready  <= w_b_done || (!r_w_held  && !w_w_fire);
      r_arready <= w_r_done || (!r_ar_held && !w_ar_fire);

      if (w_grant_wr) begin
        r_bresp      <= w_wr_legal ? RESP_OKAY : RESP_SLVERR;
        r_last_grant <= GRANT_WRITE;
      end

      if (w_grant_rd) begin
        r_rresp      <= w_rd_legal ? RESP_OKAY : RESP_SLVERR;
        r_rdata      <= w_rd_legal ? csr_rdata : 32'h0;
        r_last_grant <= GRANT_READ;
      end

      if (w_slverr && (r_err_count != C_ERR_MAX)) begin
        r_err_count <= r_err_count + 16'd1;
      end
    end
  end

  assign s_axi_awready = r_awready;
  assign s_axi_wready  = r_wready;
  assign s_axi_arready = r_arready;
  assign s_axi_bvalid  = (r_state == BRESP);
  assign s_axi_bresp   = r_bresp;
  assign s_axi_rvalid  = (r_state == RRESP);
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rdata   = r_rdata;

  // Strobes are gated by rst_n so nothing reaches the CSR block during reset.
  assign csr_wen   = rst_n && w_grant_wr && w_wr_legal;
  assign csr_ren   = rst_n && w_grant_rd && w_rd_legal;
  assign csr_addr  = w_csr_addr;
  assign csr_wdata = w_csr_wdata;
  assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_csr_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_lite_csr_bridge
//  Description : Directed self-checking bench for axi_lite_csr_bridge.
//                A stub drives csr_rdata; a monitor counts CSR strobes.
//  Ports       : none
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axi_lite_csr_bridge;

  logic        clk;
  logic        rst_n;
  logic [31:0] s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [31:0] s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic        csr_wen;
  logic        csr_ren;
  logic [7:0]  csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic [15:0] err_count;

  int checks;
  int failures;
  int wen_cnt;
  int ren_cnt;
  int both_cnt;
  int base_w;
  int base_r;

  axi_lite_csr_bridge #(.AXI_ADDR_W(32), .CSR_ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .csr_wen(csr_wen), .csr_ren(csr_ren), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .err_count(err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Strobe monitor: values sampled at the edge belong to the cycle just ending.
  always @(posedge clk) begin
    if (csr_wen) wen_cnt++;
    if (csr_ren) ren_cnt++;
    if (csr_wen && csr_ren) both_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (s_axi_awready !== 1'b0) begin failures++; $display("FAIL rst_awready got=%0b exp=0", s_axi_awready); end
    checks++; if (s_axi_wready !== 1'b0) begin failures++; $display("FAIL rst_wready got=%0b exp=0", s_axi_wready); end
    checks++; if (s_axi_arready !== 1'b0) begin failures++; $display("FAIL rst_arready got=%0b exp=0", s_axi_arready); end
    checks++; if (s_axi_bvalid !== 1'b0) begin failures++; $display("FAIL rst_bvalid got=%0b exp=0", s_axi_bvalid); end
    checks++; if (s_axi_rvalid !== 1'b0) begin failures++; $display("FAIL rst_rvalid got=%0b exp=0", s_axi_rvalid); end
    checks++; if (s_axi_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%0h exp=0", s_axi_rdata); end
    checks++; if (err_count !== 16'h0) begin failures++; $display("FAIL rst_err_count got=%0h exp=0", err_count); end
    checks++; if ({csr_wen, csr_ren} !== 2'b00) begin failures++; $display("FAIL rst_strobes got=%0b exp=00", {csr_wen, csr_ren}); end
    rst_n = 1'b1;
    checks++; if (s_axi_awready !== 1'b0) begin failures++; $display("FAIL rel_awready_early got=%0b exp=0", s_axi_awready); end
    tick();
    checks++; if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin failures++; $display("FAIL rel_readies got=%0b exp=111", {s_axi_awready, s_axi_wready, s_axi_arready}); end
  endtask

  task automatic test_aligned_write();
    base_w = wen_cnt;
    s_axi_awaddr = 32'h04; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h10; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    s_axi_bready = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    checks++; if (csr_wen !== 1'b1) begin failures++; $display("FAIL aw_wen got=%0b exp=1", csr_wen); end
    checks++; if (csr_addr !== 8'h04) begin failures++; $display("FAIL aw_addr got=%0h exp=04", csr_addr); end
    checks++; if (csr_wdata !== 32'h10) begin failures++; $display("FAIL aw_wdata got=%0h exp=10", csr_wdata); end
    checks++; if (s_axi_awready !== 1'b0) begin failures++; $display("FAIL aw_awready_held got=%0b exp=0", s_axi_awready); end
    tick();
    checks++; if (s_axi_bvalid !== 1'b1) begin failures++; $display("FAIL aw_bvalid got=%0b exp=1", s_axi_bvalid); end
    checks++; if (s_axi_bresp !== 2'b00) begin failures++; $display("FAIL aw_bresp got=%0b exp=00", s_axi_bresp); end
    checks++; if (csr_wen !== 1'b0) begin failures++; $display("FAIL aw_wen_width got=%0b exp=0", csr_wen); end
    tick();
    checks++; if (s_axi_bvalid !== 1'b0) begin failures++; $display("FAIL aw_bvalid_clear got=%0b exp=0", s_axi_bvalid); end
    checks++; if ({s_axi_awready, s_axi_wready} !== 2'b11) begin failures++; $display("FAIL aw_readies_back got=%0b exp=11", {s_axi_awready, s_axi_wready}); end
    checks++; if (wen_cnt - base_w !== 1) begin failures++; $display("FAIL aw_wen_count got=%0d exp=1", wen_cnt - base_w); end
    checks++; if (err_count !== 16'h0) begin failures++; $display("FAIL aw_err_count got=%0h exp=0", err_count); end
  endtask

  task automatic test_w_before_aw();
    base_w = wen_cnt;
    s_axi_wdata = 32'h2; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    s_axi_bready = 1'b1;
    tick();
    s_axi_wvalid = 1'b0;
    checks++; if (s_axi_wready !== 1'b0) begin failures++; $display("FAIL wa_wready_drop got=%0b exp=0", s_axi_wready); end
    checks++; if (csr_wen !== 1'b0) begin failures++; $display("FAIL wa_no_wen1 got=%0b exp=0", csr_wen); end
    tick();
    checks++; if (csr_wen !== 1'b0) begin failures++; $display("FAIL wa_no_wen2 got=%0b exp=0", csr_wen); end
    s_axi_awaddr = 32'h3C; s_axi_awvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    checks++; if (csr_wen !== 1'b1) begin failures++; $display("FAIL wa_wen got=%0b exp=1", csr_wen); end
    checks++; if (csr_addr !== 8'h3C) begin failures++; $display("FAIL wa_addr got=%0h exp=3c", csr_addr); end
    checks++; if (csr_wdata !== 32'h2) begin failures++; $display("FAIL wa_wdata got=%0h exp=2", csr_wdata); end
    tick();
    checks++; if ({s_axi_bvalid, s_axi_bresp} !== 3'b100) begin failures++; $display("FAIL wa_bresp got=%0b exp=100", {s_axi_bvalid, s_axi_bresp}); end
    tick();
    checks++; if (wen_cnt - base_w !== 1) begin failures++; $display("FAIL wa_wen_count got=%0d exp=1", wen_cnt - base_w); end
  endtask

  task automatic test_read_backpressure();
    base_r = ren_cnt;
    csr_rdata = 32'h12345678;
    s_axi_araddr = 32'h90; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
    tick();
    s_axi_arvalid = 1'b0;
    checks++; if (csr_ren !== 1'b1) begin failures++; $display("FAIL rd_ren got=%0b exp=1", csr_ren); end
    checks++; if (csr_addr !== 8'h90) begin failures++; $display("FAIL rd_addr got=%0h exp=90", csr_addr); end
    tick();
    csr_rdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      checks++; if ({s_axi_rvalid, s_axi_rresp, s_axi_rdata} !== {1'b1, 2'b00, 32'h12345678}) begin
        failures++; $display("FAIL rd_hold%0d got=%0b/%0b/%0h exp=1/00/12345678", i, s_axi_rvalid, s_axi_rresp, s_axi_rdata);
      end
      tick();
    end
    s_axi_rready = 1'b1;
    checks++; if (s_axi_rvalid !== 1'b1) begin failures++; $display("FAIL rd_still_valid got=%0b exp=1", s_axi_rvalid); end
    tick();
    checks++; if (s_axi_rvalid !== 1'b0) begin failures++; $display("FAIL rd_done got=%0b exp=0", s_axi_rvalid); end
    checks++; if (s_axi_arready !== 1'b1) begin failures++; $display("FAIL rd_arready_back got=%0b exp=1", s_axi_arready); end
    checks++; if (ren_cnt - base_r !== 1) begin failures++; $display("FAIL rd_ren_count got=%0d exp=1", ren_cnt - base_r); end
  endtask

  task automatic test_passthrough();
    csr_rdata = 32'hDEADBEEF;
    s_axi_araddr = 32'hABCDEF08; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    tick();
    s_axi_arvalid = 1'b0;
    checks++; if ({csr_ren, csr_addr} !== {1'b1, 8'h08}) begin failures++; $display("FAIL pt_ren_addr got=%0b/%0h exp=1/08", csr_ren, csr_addr); end
    tick();
    checks++; if ({s_axi_rvalid, s_axi_rresp, s_axi_rdata} !== {1'b1, 2'b00, 32'hDEADBEEF}) begin
      failures++; $display("FAIL pt_resp got=%0b/%0b/%0h exp=1/00/deadbeef", s_axi_rvalid, s_axi_rresp, s_axi_rdata);
    end
    tick();
  endtask

  task automatic test_errors();
    base_w = wen_cnt; base_r = ren_cnt;
    s_axi_awaddr = 32'h08; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'hCAFE; s_axi_wstrb = 4'h3; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    checks++; if (csr_wen !== 1'b0) begin failures++; $display("FAIL err_wen got=%0b exp=0", csr_wen); end
    tick();
    checks++; if ({s_axi_bvalid, s_axi_bresp} !== 3'b110) begin failures++; $display("FAIL err_bresp got=%0b exp=110", {s_axi_bvalid, s_axi_bresp}); end
    tick();
    csr_rdata = 32'h11112222;
    s_axi_araddr = 32'h06; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    tick();
    s_axi_arvalid = 1'b0;
    checks++; if (csr_ren !== 1'b0) begin failures++; $display("FAIL err_ren got=%0b exp=0", csr_ren); end
    tick();
    checks++; if ({s_axi_rvalid, s_axi_rresp, s_axi_rdata} !== {1'b1, 2'b10, 32'h0}) begin
      failures++; $display("FAIL err_rresp got=%0b/%0b/%0h exp=1/10/0", s_axi_rvalid, s_axi_rresp, s_axi_rdata);
    end
    tick();
    checks++; if (err_count !== 16'd2) begin failures++; $display("FAIL err_count got=%0d exp=2", err_count); end
    checks++; if ((wen_cnt - base_w) + (ren_cnt - base_r) !== 0) begin failures++; $display("FAIL err_strobes got=%0d exp=0", (wen_cnt - base_w) + (ren_cnt - base_r)); end
  endtask

  task automatic test_arbitration();
    test_reset();
    csr_rdata = 32'hA5A50001;
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    // First contended pair after reset: write wins.
    s_axi_awaddr = 32'h00; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h1; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    s_axi_araddr = 32'h3C; s_axi_arvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    checks++; if ({csr_wen, csr_ren, csr_addr} !== {2'b10, 8'h00}) begin failures++; $display("FAIL arb1_write got=%0b%0b/%0h exp=10/00", csr_wen, csr_ren, csr_addr); end
    tick();
    checks++; if ({s_axi_bvalid, csr_ren} !== 2'b10) begin failures++; $display("FAIL arb1_bvalid got=%0b exp=10", {s_axi_bvalid, csr_ren}); end
    tick();
    checks++; if ({csr_wen, csr_ren, csr_addr} !== {2'b01, 8'h3C}) begin failures++; $display("FAIL arb1_read got=%0b%0b/%0h exp=01/3c", csr_wen, csr_ren, csr_addr); end
    tick();
    checks++; if ({s_axi_rvalid, s_axi_rdata} !== {1'b1, 32'hA5A50001}) begin failures++; $display("FAIL arb1_rdata got=%0b/%0h exp=1/a5a50001", s_axi_rvalid, s_axi_rdata); end
    tick();
    // Lone write moves last_grant to WRITE.
    s_axi_awaddr = 32'h10; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h7; s_axi_wvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    checks++; if ({csr_wen, csr_addr} !== {1'b1, 8'h10}) begin failures++; $display("FAIL arb_lone got=%0b/%0h exp=1/10", csr_wen, csr_addr); end
    tick();
    tick();
    // Next contended pair: read wins, write follows.
    csr_rdata = 32'h0BADF00D;
    s_axi_awaddr = 32'h20; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h9; s_axi_wvalid = 1'b1;
    s_axi_araddr = 32'h44; s_axi_arvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    checks++; if ({csr_wen, csr_ren, csr_addr} !== {2'b01, 8'h44}) begin failures++; $display("FAIL arb2_read got=%0b%0b/%0h exp=01/44", csr_wen, csr_ren, csr_addr); end
    tick();
    checks++; if ({s_axi_rvalid, s_axi_rdata} !== {1'b1, 32'h0BADF00D}) begin failures++; $display("FAIL arb2_rdata got=%0b/%0h exp=1/0badf00d", s_axi_rvalid, s_axi_rdata); end
    tick();
    checks++; if ({csr_wen, csr_ren, csr_addr, csr_wdata} !== {2'b10, 8'h20, 32'h9}) begin
      failures++; $display("FAIL arb2_write got=%0b%0b/%0h/%0h exp=10/20/9", csr_wen, csr_ren, csr_addr, csr_wdata);
    end
    tick();
    checks++; if ({s_axi_bvalid, s_axi_bresp} !== 3'b100) begin failures++; $display("FAIL arb2_bresp got=%0b exp=100", {s_axi_bvalid, s_axi_bresp}); end
    tick();
  endtask

  task automatic test_reset_in_bresp();
    s_axi_awaddr = 32'h30; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h55; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    tick();
    checks++; if (s_axi_bvalid !== 1'b1) begin failures++; $display("FAIL rb_bvalid got=%0b exp=1", s_axi_bvalid); end
    rst_n = 1'b0;
    tick();
    checks++; if ({s_axi_bvalid, s_axi_awready, s_axi_wready, s_axi_arready} !== 4'b0000) begin
      failures++; $display("FAIL rb_reset got=%0b exp=0000", {s_axi_bvalid, s_axi_awready, s_axi_wready, s_axi_arready});
    end
    checks++; if (csr_wen !== 1'b0) begin failures++; $display("FAIL rb_wen got=%0b exp=0", csr_wen); end
    rst_n = 1'b1;
    tick();
    checks++; if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin failures++; $display("FAIL rb_readies got=%0b exp=111", {s_axi_awready, s_axi_wready, s_axi_arready}); end
    s_axi_awaddr = 32'h20; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h77; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    checks++; if ({csr_wen, csr_addr, csr_wdata} !== {1'b1, 8'h20, 32'h77}) begin
      failures++; $display("FAIL rb_fresh_wen got=%0b/%0h/%0h exp=1/20/77", csr_wen, csr_addr, csr_wdata);
    end
    tick();
    checks++; if ({s_axi_bvalid, s_axi_bresp} !== 3'b100) begin failures++; $display("FAIL rb_fresh_bresp got=%0b exp=100", {s_axi_bvalid, s_axi_bresp}); end
    tick();
  endtask

  initial begin
    checks = 0; failures = 0; wen_cnt = 0; ren_cnt = 0; both_cnt = 0;
    rst_n = 1'b0;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    s_axi_araddr = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    csr_rdata = '0;
    #1;
    test_reset();
    test_aligned_write();
    test_w_before_aw();
    test_read_backpressure();
    test_passthrough();
    test_errors();
    test_arbitration();
    test_reset_in_bresp();
    checks++; if (both_cnt !== 0) begin failures++; $display("FAIL strobe_overlap got=%0d exp=0", both_cnt); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
